seven_seg_scan_driver: RTL

- Consumes the 1 kHz clk_en strobe from the clock-enable stage and drives a 4-digit multiplexed seven-segment display showing a binary value such as credit or price.
- A sequential double-dabble converter turns the binary value into BCD.
- The scan section rotates the active digit once per clk_en strobe, giving a 250 Hz refresh per digit.

---
 rtl/seven_seg_pkg.sv | 58 +++++
 rtl/bin2bcd_seq.sv | 73 +++++++
 rtl/seven_seg_scan_driver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// converter states and digit count.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Active-high patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: +3 on every nibble >= 5
  function automatic logic [BCD_W-1:0] dd_adjust(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per clk, result held in bcd_out
// while done is high (COMMIT state).
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [VALUE_W-1:0] latched,
  output logic [BCD_W-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  conv_state_e        state_q;
  logic [VALUE_W-1:0] val_q;
  logic [VALUE_W-1:0] sh_q;
  logic [BCD_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [BCD_W-1:0]   adj;

  assign adj = dd_adjust(scr_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      val_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            val_q   <= bin_in;
            sh_q    <= bin_in;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(VALUE_W)) begin
            state_q <= COMMIT;
          end else begin
            scr_q <= {adj[BCD_W-2:0], sh_q[VALUE_W-1]};
            sh_q  <= {sh_q[VALUE_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = (state_q == COMMIT);
  assign latched = val_q;
  assign bcd_out = scr_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// 4-digit multiplexed seven-segment driver with sequential BCD conversion.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W        = 14,
  parameter int MAX_VALUE      = 9999,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               clk_en,
  input  logic [VALUE_W-1:0] value_in,
  input  logic [3:0]         dp_mask,
  input  logic               blank,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               busy
);

  localparam bit         INV     = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = INV ? ~SEG_BLANK : SEG_BLANK;
  localparam logic       DP_OFF  = INV;

  logic [VALUE_W-1:0] value_sat;
  logic [VALUE_W-1:0] latched;
  logic               conv_start;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0]         dig;
  logic [3:0]         lz;
  logic [3:0]         an_dec;
  logic [6:0]         seg_raw;
  logic [6:0]         seg_dec;
  logic               dp_dec;

  assign value_sat = (value_in > VALUE_W'(MAX_VALUE))
                   ? VALUE_W'(MAX_VALUE) : value_in;
  assign conv_start = (value_sat != latched);

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk     (clk),
    .clr     (clr),
    .start   (conv_start),
    .bin_in  (value_sat),
    .busy    (conv_busy),
    .done    (conv_done),
    .latched (latched),
    .bcd_out (conv_bcd)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  always_comb begin
    z3 = (disp_q[15:12] == 4'd0);
    z2 = z3 && (disp_q[11:8] == 4'd0);
    z1 = z2 && (disp_q[7:4] == 4'd0);
    lz = {z3 && !dp_mask[3],
          z2 && !dp_mask[2],
          z1 && !dp_mask[1],
          1'b0};
  end
`else
  assign lz = 4'b0000;
`endif

  // Scan registers sample disp_q, so a commit on a strobe edge shows
  // the old value until the next strobe.
  always_comb begin
    disp_d  = conv_done ? conv_bcd : disp_q;
    idx_d   = clk_en ? idx_q + 2'd1 : idx_q;
    dig     = disp_q[{idx_q, 2'b00} +: 4];
    an_dec  = lz[idx_q] ? 4'hF : ~(4'b0001 << idx_q);
    seg_raw = bcd_to_seg(dig);
    seg_dec = INV ? ~seg_raw : seg_raw;
    dp_dec  = dp_mask[idx_q] ^ INV;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (clk_en) begin
      an_d  = an_dec;
      seg_d = seg_dec;
      dp_d  = dp_dec;
    end
    if (blank)
      an_d = 4'hF;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      disp_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'hF;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
    end else begin
      disp_q <= disp_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = conv_busy;

endmodule
